// File: rtl/fp_pkg.sv
// Shared types and constants for the floating-point adder back end.
package fp_pkg;

   localparam int EXP_W = 8;
   localparam int MAN_W = 23;

   localparam logic [31:0] FP_POS_INF = 32'h7F800000;
   localparam logic [7:0]  EXP_MAX    = 8'hFF;

   // Normalised but not yet rounded result carried from S1 to S2
   typedef struct packed {
      logic [MAN_W:0] mant;
      logic [EXP_W:0] exp9;
      logic           r;
      logic           s;
      logic           special_inf;
      logic           zero;
   } s1_payload_t;

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a normalised significand, with exponent
// bump on mantissa carry-out and overflow detection.
module fp_round_rne (
   input  logic [fp_pkg::MAN_W:0]   mant,
   input  logic [fp_pkg::EXP_W:0]   exp9,
   input  logic                     r,
   input  logic                     s,
   output logic [fp_pkg::MAN_W-1:0] frac,
   output logic [fp_pkg::EXP_W-1:0] exp,
   output logic                     overflow
);
   import fp_pkg::*;

   logic           round_up;
   logic [EXP_W:0] exp_r;

   // Round up on more-than-half, or exactly half with an odd lsb; an all-ones
   // significand wraps to 1.000... and pushes the exponent up by one
   always_comb begin
      round_up = r & (s | mant[0]);
      frac     = mant[MAN_W-1:0];
      exp_r    = exp9;
      if (round_up && (&mant)) begin
         frac  = '0;
         exp_r = exp9 + 1'b1;
      end else begin
         frac  = mant[MAN_W-1:0] + MAN_W'(round_up);
      end
      exp      = exp_r[EXP_W-1:0];
      overflow = (exp_r >= {1'b0, EXP_MAX});
   end

endmodule

// File: rtl/fp_add_norm_round.sv
// Normalise / round-to-nearest-even / pack stage of the positive-only
// single-precision adder. Two-entry valid/ready pipeline (S1 normalise,
// S2 round and pack into the output register).
// Optional macro FP_NORM_STATUS_EN adds sticky overflow/inexact flags.
module fp_add_norm_round #(
   parameter int EXP_W = fp_pkg::EXP_W,
   parameter int MAN_W = fp_pkg::MAN_W
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [EXP_W-1:0]       in_exp,
   input  logic [MAN_W:0]         in_sum,
   input  logic                   in_cout,
   input  logic                   in_guard,
   input  logic                   in_sticky,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+MAN_W:0]   out_data
`ifdef FP_NORM_STATUS_EN
   ,
   input  logic                   status_clr,
   output logic [1:0]             status_flags
`endif
);
   import fp_pkg::*;

   s1_payload_t             s1_next;
   s1_payload_t             s1_q;
   logic                    s1_valid;
   logic                    s1_en;
   logic                    s2_en;
   logic [MAN_W-1:0]        rnd_frac;
   logic [EXP_W-1:0]        rnd_exp;
   logic                    rnd_ovf;
   logic [EXP_W+MAN_W:0]    packed_res;
   logic                    packed_ovf;

   // A stage may load when it is empty or its contents leave this cycle
   always_comb begin
      s2_en    = !out_valid || out_ready;
      s1_en    = !s1_valid || s2_en;
      in_ready = rst_n && s1_en;
   end

   // S1: fold the adder carry-out back into a 24-bit significand
   always_comb begin
      s1_next = '0;
      if (in_cout) begin
         s1_next.mant = {1'b1, in_sum[MAN_W:1]};
         s1_next.r    = in_sum[0];
         s1_next.s    = in_guard | in_sticky;
         s1_next.exp9 = {1'b0, in_exp} + 1'b1;
      end else begin
         s1_next.mant = in_sum;
         s1_next.r    = in_guard;
         s1_next.s    = in_sticky;
         s1_next.exp9 = {1'b0, in_exp};
      end
      s1_next.special_inf = (in_exp == EXP_MAX);
      s1_next.zero        = (in_exp == '0) && (in_sum == '0) && !in_cout;
   end

   // S1 register: holds its entry until S2 can take it
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_q     <= '0;
      end else if (s1_en) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_q <= s1_next;
         end
      end
   end

   fp_round_rne u_round (
      .mant     (s1_q.mant),
      .exp9     (s1_q.exp9),
      .r        (s1_q.r),
      .s        (s1_q.s),
      .frac     (rnd_frac),
      .exp      (rnd_exp),
      .overflow (rnd_ovf)
   );

   // S2 pack: infinity input beats rounding overflow, which beats zero
   always_comb begin
      packed_res = {1'b0, rnd_exp, rnd_frac};
      packed_ovf = 1'b0;
      if (s1_q.special_inf) begin
         packed_res = FP_POS_INF;
      end else if (rnd_ovf) begin
         packed_res = FP_POS_INF;
         packed_ovf = 1'b1;
      end else if (s1_q.zero) begin
         packed_res = '0;
      end
   end

   // S2 / output register: frozen while the consumer stalls
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (s2_en) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_data <= packed_res;
         end
      end
   end

`ifdef FP_NORM_STATUS_EN
   logic       out_ovf;
   logic       out_inexact;
   logic [1:0] flags_q;

   // Per-result status bits travel alongside out_data
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_ovf     <= 1'b0;
         out_inexact <= 1'b0;
      end else if (s2_en && s1_valid) begin
         out_ovf     <= packed_ovf;
         out_inexact <= s1_q.r | s1_q.s;
      end
   end

   // Sticky flags: a handshaking result sets them, and a set beats a clear
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         flags_q <= 2'b00;
      end else begin
         flags_q <= (status_clr ? 2'b00 : flags_q)
                  | ((out_valid && out_ready) ? {out_ovf, out_inexact} : 2'b00);
      end
   end

   assign status_flags = flags_q;
`else
   // Overflow is only reported through the optional status flags
   logic unused_ovf;
   assign unused_ovf = packed_ovf;
`endif

endmodule

// File: tb/tb_fp_add_norm_round.sv
// Scoreboard bench for fp_add_norm_round: a driver pushes expected results
// computed from an arithmetic rounding model, a monitor pops and compares.
module tb_fp_add_norm_round;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_exp;
   logic [23:0] in_sum;
   logic        in_cout;
   logic        in_guard;
   logic        in_sticky;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_data;
`ifdef FP_NORM_STATUS_EN
   logic        status_clr;
   logic [1:0]  status_flags;
`endif

   int          total = 0;
   int          bad = 0;
   int          ready_mode = 0;
   logic [31:0] sb[$];
   logic        prev_hold = 1'b0;
   logic [31:0] held_data = '0;

   fp_add_norm_round dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_exp    (in_exp),
      .in_sum    (in_sum),
      .in_cout   (in_cout),
      .in_guard  (in_guard),
      .in_sticky (in_sticky),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
`ifdef FP_NORM_STATUS_EN
      ,
      .status_clr   (status_clr),
      .status_flags (status_flags)
`endif
   );

   always #5 clk = ~clk;

   // Exact value in quarter-ulp units, divided down to 24 bits with RNE
   function automatic logic [31:0] ref_model(input logic [7:0] e, input logic [23:0] sm,
                                             input logic c, input logic g, input logic st);
      longint      q;
      longint      ulp;
      longint      base;
      longint      rem;
      int          ex;
      logic [63:0] b;
      q    = ((longint'(c) << 24) + longint'(sm)) * 4 + longint'(g) * 2 + longint'(st);
      ulp  = c ? 8 : 4;
      base = q / ulp;
      rem  = q % ulp;
      if (rem > ulp / 2 || (rem == ulp / 2 && (base % 2) == 1)) base = base + 1;
      ex = int'(e) + int'(c);
      if (base == (longint'(1) << 24)) begin
         base = base / 2;
         ex   = ex + 1;
      end
      b = 64'(base);
      if (e == 8'd255) return 32'h7F800000;
      if (ex >= 255) return 32'h7F800000;
      if (e == 8'd0 && sm == 24'd0 && !c) return 32'h0;
      return {1'b0, 8'(ex), b[22:0]};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // Drive one transfer and record its expected result at the accepting edge
   task automatic applyStimulus(input logic [7:0] e, input logic [23:0] sm, input logic c,
                                input logic g, input logic st, input logic [31:0] expv);
      int waited = 0;
      in_exp = e; in_sum = sm; in_cout = c; in_guard = g; in_sticky = st;
      in_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (in_ready) begin
            sb.push_back(expv);
            break;
         end
         waited++;
         if (waited > 500) begin
            total++; bad++;
            $display("[TB] FAIL accept_timeout: in_ready stuck at %b, expected 1", in_ready);
            break;
         end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while ((sb.size() != 0 || out_valid) && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 500) begin
         total++; bad++;
         $display("[TB] FAIL %s: %0d results outstanding, expected 0", name, sb.size());
      end
   endtask

   // Consumer readiness pattern: 0 always ready, 1 stalled, 2 random
   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0: out_ready = 1'b1;
         1: out_ready = 1'b0;
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
   end

   // Monitor: pop and compare each delivered result; check held outputs stay put
   always @(negedge clk) begin
      if (!rst_n) begin
         sb.delete();
         prev_hold = 1'b0;
      end else begin
         if (prev_hold && out_valid) checkOutput("hold_stable", out_data, held_data);
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               total++; bad++;
               $display("[TB] FAIL unexpected_output: got %h, expected no result", out_data);
            end else begin
               checkOutput("result", out_data, sb.pop_front());
            end
         end
         prev_hold = out_valid && !out_ready;
         held_data = out_data;
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [7:0]  e;
      logic [23:0] sm;
      logic        c, g, st;
      int          pick;
      rst_n = 1'b0; in_valid = 1'b0;
      in_exp = '0; in_sum = '0; in_cout = 1'b0; in_guard = 1'b0; in_sticky = 1'b0;
`ifdef FP_NORM_STATUS_EN
      status_clr = 1'b0;
`endif
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
      checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
      checkOutput("reset_out_data", out_data, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Directed vectors
      applyStimulus(8'd127, 24'h800000, 1'b1, 1'b0, 1'b0, 32'h40400000);
      applyStimulus(8'd127, 24'hC00001, 1'b0, 1'b1, 1'b0, 32'h3FC00002);
      applyStimulus(8'd127, 24'hC00002, 1'b0, 1'b1, 1'b0, 32'h3FC00002);
      applyStimulus(8'd130, 24'hFFFFFF, 1'b0, 1'b1, 1'b1, 32'h41800000);
      applyStimulus(8'd0,   24'h000000, 1'b0, 1'b0, 1'b0, 32'h00000000);
      applyStimulus(8'd255, 24'h800000, 1'b0, 1'b0, 1'b0, 32'h7F800000);
      drain("directed_drain");

`ifdef FP_NORM_STATUS_EN
      status_clr = 1'b1;
      @(posedge clk); #1;
      status_clr = 1'b0;
`endif
      applyStimulus(8'd254, 24'h800000, 1'b1, 1'b0, 1'b0, 32'h7F800000);
      drain("overflow_drain");
`ifdef FP_NORM_STATUS_EN
      @(negedge clk);
      checkOutput("status_overflow", 32'(status_flags[1]), 32'd1);
      @(posedge clk); #1;
      status_clr = 1'b1;
      @(posedge clk); #1;
      status_clr = 1'b0;
      @(negedge clk);
      checkOutput("status_cleared", 32'(status_flags), 32'd0);
      @(posedge clk); #1;
`endif

      // Backpressure: two accepts fill the pipe, then input stalls
      ready_mode = 1;
      repeat (2) @(posedge clk);
      #1;
      applyStimulus(8'd100, 24'h812345, 1'b0, 1'b0, 1'b0, ref_model(8'd100, 24'h812345, 1'b0, 1'b0, 1'b0));
      applyStimulus(8'd101, 24'hA00001, 1'b1, 1'b1, 1'b0, ref_model(8'd101, 24'hA00001, 1'b1, 1'b1, 1'b0));
      in_exp = 8'd102; in_sum = 24'hFFFFFE; in_cout = 1'b0; in_guard = 1'b1; in_sticky = 1'b0;
      in_valid = 1'b1;
      repeat (2) begin
         @(negedge clk);
         checkOutput("bp_in_ready_low", 32'(in_ready), 32'd0);
         checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
      end
      ready_mode = 0;
      applyStimulus(8'd102, 24'hFFFFFE, 1'b0, 1'b1, 1'b0, ref_model(8'd102, 24'hFFFFFE, 1'b0, 1'b1, 1'b0));
      applyStimulus(8'd103, 24'hC00003, 1'b0, 1'b1, 1'b1, ref_model(8'd103, 24'hC00003, 1'b0, 1'b1, 1'b1));
      drain("bp_drain");

      // Reset with both stages full: nothing in flight may come out later
      ready_mode = 1;
      repeat (2) @(posedge clk);
      #1;
      applyStimulus(8'd90, 24'h900000, 1'b0, 1'b0, 1'b0, 32'h0);
      applyStimulus(8'd91, 24'h900000, 1'b0, 1'b0, 1'b0, 32'h0);
      rst_n = 1'b0;
      @(negedge clk);
      checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      ready_mode = 0;
      @(negedge clk);
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      repeat (10) @(posedge clk);
      #1;

      // Randomised traffic with random consumer stalls
      ready_mode = 2;
      for (int i = 0; i < 300; i++) begin
         pick = int'($urandom_range(0, 9));
         case (pick)
            0: e = 8'd0;
            1: e = 8'd254;
            2: e = 8'd255;
            3: e = 8'd253;
            default: e = 8'($urandom_range(1, 254));
         endcase
         sm = 24'($urandom) | 24'h800000;
         if ($urandom_range(0, 7) == 0) sm = 24'hFFFFFF;
         c  = 1'($urandom_range(0, 1));
         g  = 1'($urandom_range(0, 1));
         st = 1'($urandom_range(0, 1));
         if (pick == 0 && $urandom_range(0, 1) == 1) begin
            sm = 24'h0;
            c  = 1'b0;
         end
         applyStimulus(e, sm, c, g, st, ref_model(e, sm, c, g, st));
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #0;
      end
      ready_mode = 0;
      drain("random_drain");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fp_add_norm_round.md
Name: fp_add_norm_round

Overview:
- Downstream stage of the 32-bit positive floating-point adder datapath.
- Consumes the raw adder result: max exponent, 24-bit sum, carry-out, plus guard/sticky bits from the alignment shifter.
- Normalises, rounds to nearest-even, and handles overflow to +infinity.
- Two-stage valid/ready pipeline producing a packed IEEE-754 single-precision result.

Parameters:
- EXP_W, 8, exponent width.
- MAN_W, 23, stored mantissa width; significand is MAN_W+1 bits including the hidden bit.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  synchronous reset, active-low.
- in_valid  input  1  upstream result valid.
- in_ready  output  1  stage accepts input this cycle.
- in_exp  input  8  max(EA,EB) before carry adjustment.
- in_sum  input  24  24-bit adder sum; bit 23 is the hidden bit.
- in_cout  input  1  adder carry-out.
- in_guard  input  1  first bit shifted out by the alignment shifter.
- in_sticky  input  1  OR of all further shifted-out bits.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_data  output  32  packed result {sign=0, exp, mantissa}.

Behaviour:
- Reset: synchronous on the clk edge with rst_n=0.
  - s1_valid, s2_valid, out_valid and out_data clear to 0.
  - in_ready is forced 0 while rst_n=0.
  - Reset mid-transfer discards all in-flight data; no partial output.
- Handshake:
  - A transfer occurs when valid&&ready.
  - in_ready = rst_n && (!s1_valid || !s2_valid || out_ready).
  - Each stage advances only when the next slot is empty or draining.
  - Throughput is 1 result/cycle.
  - Latency is 2 cycles: a result accepted at edge N is valid at edge N+2 when out_ready=1.
  - out_data and out_valid hold stable while out_valid && !out_ready.
- Stage S1 (normalise):
  - in_cout=1: mant = {1,in_sum[23:1]}, r = in_sum[0], s = in_guard|in_sticky, exp9 = in_exp+1.
  - in_cout=0: mant = in_sum, r = in_guard, s = in_sticky, exp9 = {0,in_exp}.
  - Flags: special_inf = (in_exp==255); zero = (in_exp==0 && in_sum==0 && !in_cout).
- Stage S2 (round and pack):
  - round_up = r && (s || mant[0]).
  - If round_up and mant==24'hFFFFFF: mant becomes 24'h800000 and exp9 increments.
  - Otherwise mant = mant + round_up.
  - Priority order, highest first:
    - special_inf → 32'h7F800000.
    - exp9 >= 255 → 32'h7F800000, overflow.
    - zero → 32'h00000000.
    - else → {1'b0, exp9[7:0], mant[22:0]}.
  - Sign is always 0 (positive-only datapath).
- Boundaries:
  - Simultaneous input accept and output drain with both stages full: the pipeline shifts and keeps full throughput.
  - Denormal inputs are outside scope; in_exp=0 with nonzero sum packs as-is.

Optional Feature:
- Macro: FP_NORM_STATUS_EN.
- Defined: adds input status_clr (1) and output status_flags (2) = {overflow_sticky, inexact_sticky}.
  - Flags are set when a result handshakes out with overflow or with (r|s)=1.
  - status_clr clears them next cycle; if a set and status_clr coincide, the set wins.
  - Both flags reset to 0.
- Undefined: neither port nor the flag logic exists; datapath is unchanged.

Decomposition:
- Shared package fp_pkg:
  - EXP_W, MAN_W.
  - FP_POS_INF = 32'h7F800000.
  - EXP_MAX = 8'hFF.
  - Typedef s1_payload_t {mant[23:0], exp9[8:0], r, s, special_inf, zero}.
- One natural sub-module: fp_round_rne. It is combinational mant/exp9/r/s → rounded mant/exp9/overflow, instantiated in S2.

Test Plan:
- 1.5+1.5: in_exp=127, in_sum=24'h800000, in_cout=1, guard/sticky=0 → out_data 32'h40400000 two cycles later.
- Tie to even: in_cout=0, in_sum=24'hC00001, in_guard=1, in_sticky=0, in_exp=127 → mantissa rounds up to 24'hC00002 → 32'h3FC00002. Same with in_sum=24'hC00002 → 32'h3FC00002 (no increment).
- Round carry-out: in_sum=24'hFFFFFF, in_guard=1, in_sticky=1, in_exp=130, in_cout=0 → 32'h41800000.
- Overflow: in_exp=254, in_cout=1 → 32'h7F800000. With FP_NORM_STATUS_EN, status_flags[1]=1 until status_clr.
- Backpressure: stream 4 back-to-back inputs with out_ready low for 3 cycles → in_ready drops after 2 accepts, out_data stays stable, all 4 results emerge in order with none lost or duplicated.
- Reset mid-stream: rst_n=0 for one cycle with both stages full → out_valid=0 next cycle, no stale result emitted afterwards.
